ppu_line_buf: RTL and testbench

PPU_LINE_BUF -- requirements
Module: ppu_line_buf

---
 rtl/ppu_line_buf.sv | 138 +++++++++++++
 tb/tb_ppu_line_buf.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ppu_line_buf.sv
// Double-buffered NES scanline buffer between the PPU renderer and the VGA scan-out.
// The renderer fills the back bank; on each VGA line change, a full back bank is swapped
// in as the show bank. Otherwise an underrun is flagged and the old line stays visible.
// Optional feature macro: PPU_LINEBUF_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter.
module ppu_line_buf #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned IDX_W  = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_valid_in,
  input  logic [IDX_W-1:0] wr_idx_in,
  output logic             wr_ready_out,
  input  logic             frame_start_in,
  input  logic [9:0]       nes_x_in,
  input  logic [9:0]       nes_y_in,
  output logic [IDX_W-1:0] sys_palette_idx_out,
  output logic             underrun_out,
  output logic [15:0]      underrun_cnt_out
);

  localparam int unsigned    PtrW     = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(LINE_W - 1);
  localparam logic [IDX_W-1:0] IdxBlank = IDX_W'(15);

  // Bank RAMs; show_sel_q picks which one VGA reads, the other is the back bank.
  logic [IDX_W-1:0] bank0 [LINE_W];
  logic [IDX_W-1:0] bank1 [LINE_W];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic             back_full_q, back_full_d;
  logic             show_sel_q, show_sel_d;
  logic             show_valid_q, show_valid_d;
  logic [9:0]       y_q;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             underrun_q, underrun_d;

  logic             line_change;
  logic             wr_en;
  logic [PtrW-1:0]  wr_addr;
  logic [PtrW-1:0]  rd_addr;
  logic             rd_in_range;

  assign wr_ready_out        = ~back_full_q;
  assign sys_palette_idx_out = rd_idx_q;
  assign underrun_out        = underrun_q;

  // Write-side decode: a frame start rewinds the pointer for this very write.
  always_comb begin
    line_change = (nes_y_in != y_q);
    wr_en       = wr_valid_in & ~back_full_q;
    wr_addr     = frame_start_in ? '0 : wr_ptr_q;
    rd_in_range = ({22'd0, nes_x_in} < LINE_W);
    rd_addr     = PtrW'(nes_x_in);
  end

  // Next-state for pointer, bank flags and underrun; read uses pre-edge bank select.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    back_full_d  = back_full_q;
    show_sel_d   = show_sel_q;
    show_valid_d = show_valid_q;
    underrun_d   = line_change & ~back_full_q;
    rd_idx_d     = IdxBlank;

    if (line_change && back_full_q) begin
      show_sel_d   = ~show_sel_q;
      back_full_d  = 1'b0;
      show_valid_d = 1'b1;
    end

    if (frame_start_in) begin
      wr_ptr_d    = '0;
      back_full_d = 1'b0;
    end

    // wr_en implies back_full_q == 0, so it never overlaps a swap.
    if (wr_en) begin
      if (wr_addr == PtrLast) begin
        wr_ptr_d = '0;
        if (!frame_start_in) back_full_d = 1'b1;
      end else begin
        wr_ptr_d = wr_addr + PtrW'(1);
      end
    end

    if (rd_in_range && show_valid_q) begin
      rd_idx_d = show_sel_q ? bank1[rd_addr] : bank0[rd_addr];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q     <= '0;
      back_full_q  <= 1'b0;
      show_sel_q   <= 1'b0;
      show_valid_q <= 1'b0;
      y_q          <= '0;
      rd_idx_q     <= IdxBlank;
      underrun_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      back_full_q  <= back_full_d;
      show_sel_q   <= show_sel_d;
      show_valid_q <= show_valid_d;
      y_q          <= nes_y_in;
      rd_idx_q     <= rd_idx_d;
      underrun_q   <= underrun_d;
    end
  end

  // Pixel writes always land in the bank not selected for display.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      if (show_sel_q) bank0[wr_addr] <= wr_idx_in;
      else            bank1[wr_addr] <= wr_idx_in;
    end
  end

`ifdef PPU_LINEBUF_UNDERRUN_CNT_EN
  logic [15:0] cnt_q;

  // Saturating count, stepped alongside the underrun pulse register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (underrun_d && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign underrun_cnt_out = cnt_q;
`else
  assign underrun_cnt_out = '0;
`endif

endmodule

// File: tb/tb_ppu_line_buf.sv
// Bench for ppu_line_buf: directed vector table plus randomized traffic against a
// line-level model (back line as a queue of pixels, show line as an array).
module tb_ppu_line_buf;

  localparam int LineW = 256;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       wr_valid_in;
  logic [5:0] wr_idx_in;
  logic       wr_ready_out;
  logic       frame_start_in;
  logic [9:0] nes_x_in;
  logic [9:0] nes_y_in;
  logic [5:0] sys_palette_idx_out;
  logic       underrun_out;
  logic [15:0] underrun_cnt_out;

  ppu_line_buf #(.LINE_W(256), .IDX_W(6)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .wr_valid_in         (wr_valid_in),
    .wr_idx_in           (wr_idx_in),
    .wr_ready_out        (wr_ready_out),
    .frame_start_in      (frame_start_in),
    .nes_x_in            (nes_x_in),
    .nes_y_in            (nes_y_in),
    .sys_palette_idx_out (sys_palette_idx_out),
    .underrun_out        (underrun_out),
    .underrun_cnt_out    (underrun_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [5:0] m_show [LineW];
  bit         m_show_valid;
  logic [5:0] m_back [$];
  logic [9:0] m_qy;
  int         m_cnt;
  logic [5:0] exp_idx;
  bit         exp_ur;

  typedef struct {
    int         n;
    bit         wv;
    bit         imode;   // 1: pixel value = index within record, 0: cidx
    logic [5:0] cidx;
    bit         fs;
    int         x;
    int         y;
    logic [5:0] e_idx;
    bit         e_ur;
    bit         e_rdy;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_back.delete();
    m_show_valid = 0;
    m_qy = '0;
    m_cnt = 0;
  endtask

  task automatic model_step(input bit wv, input logic [5:0] idx, input bit fs,
                            input int x, input int y);
    bit full_pre;
    bit lc;
    full_pre = (m_back.size() == LineW);
    exp_idx = (x >= LineW || !m_show_valid) ? 6'h0F : m_show[x];
    lc = (10'(y) != m_qy);
    exp_ur = lc && !full_pre;
    if (lc && full_pre) begin
      for (int i = 0; i < LineW; i++) m_show[i] = m_back[i];
      m_back.delete();
      m_show_valid = 1;
    end
    if (fs) m_back.delete();
    if (wv && !full_pre) m_back.push_back(idx);
    m_qy = 10'(y);
`ifdef PPU_LINEBUF_UNDERRUN_CNT_EN
    if (exp_ur && m_cnt < 65535) m_cnt++;
`endif
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".idx"}, int'(sys_palette_idx_out), int'(exp_idx));
    chk({tag, ".underrun"}, int'(underrun_out), int'(exp_ur));
    chk({tag, ".ready"}, int'(wr_ready_out), int'(m_back.size() != LineW));
    chk({tag, ".cnt"}, int'(underrun_cnt_out), m_cnt);
  endtask

  task automatic step(input bit wv, input logic [5:0] idx, input bit fs,
                      input int x, input int y, input string tag);
    wr_valid_in    = wv;
    wr_idx_in      = idx;
    frame_start_in = fs;
    nes_x_in       = 10'(x);
    nes_y_in       = 10'(y);
    model_step(wv, idx, fs, x, y);
    @(posedge clk_in);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    rst_in = 1'b1;
    wr_valid_in = 1'b0;
    frame_start_in = 1'b0;
    model_reset();
    exp_idx = 6'h0F;
    exp_ur = 0;
    repeat (cycles) begin
      @(posedge clk_in);
      #1;
      check_model(tag);
    end
    rst_in = 1'b0;
  endtask

  task automatic add(input int n, input bit wv, input bit imode, input logic [5:0] cidx,
                     input bit fs, input int x, input int y, input logic [5:0] e_idx,
                     input bit e_ur, input bit e_rdy);
    vec_t v;
    v = '{n, wv, imode, cidx, fs, x, y, e_idx, e_ur, e_rdy};
    tbl.push_back(v);
  endtask

  initial begin
    int y_cur;
    rst_in = 1'b1;
    wr_valid_in = 1'b0;
    wr_idx_in = '0;
    frame_start_in = 1'b0;
    nes_x_in = '0;
    nes_y_in = '0;

    //   n    wv imode cidx   fs x    y  e_idx  ur rdy
    add(1,   0, 0, 6'h00, 0, 5,   0, 6'h0F, 0, 1);  // no line shown yet
    add(256, 1, 1, 6'h00, 0, 0,   0, 6'h0F, 0, 0);  // fill x[5:0]
    add(4,   1, 0, 6'h2A, 0, 0,   0, 6'h0F, 0, 0);  // held valid, no room
    add(1,   0, 0, 6'h00, 0, 5,   1, 6'h0F, 0, 1);  // swap, read uses old bank
    add(1,   0, 0, 6'h00, 0, 5,   1, 6'h05, 0, 1);
    add(1,   0, 0, 6'h00, 0, 300, 1, 6'h0F, 0, 1);  // out of range
    add(1,   0, 0, 6'h00, 0, 2,   1, 6'h02, 0, 1);  // blocked writes did not land
    add(1,   0, 0, 6'h00, 0, 255, 1, 6'h3F, 0, 1);
    add(100, 1, 0, 6'h11, 0, 10,  1, 6'h0A, 0, 1);
    add(1,   0, 0, 6'h00, 0, 10,  2, 6'h0A, 1, 1);  // underrun
    add(1,   0, 0, 6'h00, 0, 10,  2, 6'h0A, 0, 1);  // old bank still shown
    add(155, 1, 0, 6'h22, 0, 0,   2, 6'h00, 0, 1);
    add(1,   1, 0, 6'h22, 0, 0,   3, 6'h00, 1, 0);  // last write + line change
    add(1,   0, 0, 6'h00, 0, 20,  4, 6'h14, 0, 1);  // deferred swap
    add(1,   0, 0, 6'h00, 0, 20,  4, 6'h11, 0, 1);
    add(1,   0, 0, 6'h00, 0, 150, 4, 6'h22, 0, 1);
    add(40,  1, 0, 6'h33, 0, 0,   4, 6'h11, 0, 1);
    add(1,   0, 0, 6'h00, 1, 0,   4, 6'h11, 0, 1);  // frame start discards 40
    add(256, 1, 1, 6'h00, 0, 0,   4, 6'h11, 0, 0);
    add(1,   0, 0, 6'h00, 0, 39,  5, 6'h11, 0, 1);
    add(1,   0, 0, 6'h00, 0, 39,  5, 6'h27, 0, 1);
    add(10,  1, 0, 6'h05, 0, 0,   5, 6'h00, 0, 1);
    add(1,   1, 0, 6'h3C, 1, 0,   5, 6'h00, 0, 1);  // frame start + write -> addr 0
    add(255, 1, 1, 6'h00, 0, 0,   5, 6'h00, 0, 0);
    add(1,   0, 0, 6'h00, 0, 0,   6, 6'h00, 0, 1);
    add(1,   0, 0, 6'h00, 0, 0,   6, 6'h3C, 0, 1);
    add(1,   0, 0, 6'h00, 0, 1,   6, 6'h00, 0, 1);
    add(256, 1, 0, 6'h07, 0, 0,   6, 6'h3C, 0, 0);
    add(1,   0, 0, 6'h00, 1, 1,   7, 6'h00, 0, 1);  // frame start + swap
    add(1,   0, 0, 6'h00, 0, 1,   7, 6'h07, 0, 1);

    do_reset(3, "reset");

    foreach (tbl[k]) begin
      for (int i = 0; i < tbl[k].n; i++) begin
        step(tbl[k].wv, tbl[k].imode ? 6'(i) : tbl[k].cidx, tbl[k].fs && (i == 0),
             tbl[k].x, tbl[k].y, $sformatf("vec%0d.model", k));
      end
      chk($sformatf("vec%0d.idx", k), int'(sys_palette_idx_out), int'(tbl[k].e_idx));
      chk($sformatf("vec%0d.underrun", k), int'(underrun_out), int'(tbl[k].e_ur));
      chk($sformatf("vec%0d.ready", k), int'(wr_ready_out), int'(tbl[k].e_rdy));
    end

    // Randomized traffic, with a mid-line reset halfway through.
    y_cur = 7;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset(2, "midreset");
      if ($urandom_range(0, 279) == 0) y_cur = (y_cur + 1) % 1024;
      step($urandom_range(0, 9) < 8, 6'($urandom), $urandom_range(0, 499) == 0,
           int'($urandom_range(0, 319)), y_cur, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
